// File: rtl/function_generator.sv
// -----------------------------------------------------------------------------
// function_generator
//   Wishbone-programmable arbitrary waveform generator. Firmware fills a small
//   sample RAM and programs PERIOD (clocks per sample minus one) and LAST
//   (index of the final sample). While CTRL.RUN is set the core replays
//   RAM[0..LAST] cyclically onto the 8-bit DAC bus.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, asynchronous active-high reset
//   active                 project select; 0 blocks bus access and zeroes outputs
//   wbs_*                  Wishbone slave (single-cycle ack one clock after a hit)
//   dac                    current sample
//   dbg_*                  debug strobes (index zero, RUN state, DAC update,
//                          RAM-window strobe, raw bus strobe, active copy)
// -----------------------------------------------------------------------------
module function_generator #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          RAM_DEPTH = 32,
    parameter int          AW        = 5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        active,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  dac,
    output logic        dbg_ram_addr_zero,
    output logic        dbg_state_run,
    output logic        dbg_dac_start,
    output logic        dbg_ram_wb_stb,
    output logic        dbg_caravel_wb_stb,
    output logic        dbg_active
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [10:0] OFF_CTRL   = 11'h000;
    localparam logic [10:0] OFF_PERIOD = 11'h004;
    localparam logic [10:0] OFF_LAST   = 11'h008;

    // Sample RAM occupies word offsets 0x400 + 4*i for i < RAM_DEPTH; the rest
    // of the upper half of the window is unmapped.
    function automatic logic is_ram_off(input logic [10:0] off);
        return off[10] && (off[9:AW+2] == {(8-AW){1'b0}}) && (off[1:0] == 2'b00);
    endfunction

    // Bus decode
    logic            bus_req_s;
    logic            win_s;
    logic            hit_s;
    logic            ram_sel_s;
    logic [10:0]     off_s;
    logic [AW-1:0]   ram_idx_s;
    logic [31:0]     rdata_s;
    logic            unused_s;

    // Bus transaction registers
    logic            ack_q;
    logic [31:0]     dat_q;
    logic            req_wr_q;
    logic [10:0]     req_off_q;
    logic [15:0]     req_dat_q;

    // Programming registers
    logic            run_q;
    logic [15:0]     period_q;
    logic [AW-1:0]   last_q;

    // Playback
    state_t          state_q;
    logic [AW-1:0]   index_q;
    logic [AW-1:0]   index_d;
    logic [15:0]     cnt_q;
    logic [7:0]      dac_q;
    logic            dac_start_q;
    logic [7:0]      ram_q [RAM_DEPTH];

    assign bus_req_s = wbs_stb_i & wbs_cyc_i;
    // BASE_ADDR is 2 KiB aligned, so the window test is a compare of the upper bits.
    assign win_s     = (wbs_adr_i[31:11] == BASE_ADDR[31:11]);
    assign off_s     = wbs_adr_i[10:0];
    assign ram_sel_s = is_ram_off(off_s);
    assign ram_idx_s = off_s[AW+1:2];
    // Blocking on ack_q keeps a still-asserted strobe from re-triggering in the ack cycle.
    assign hit_s     = bus_req_s & active & win_s & ~ack_q;
    assign unused_s  = ^{wbs_sel_i[3:1], wbs_dat_i[31:16]};

    // Read-data mux for the addressed register or RAM word
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (ram_sel_s) begin
            rdata_s = {24'h00_0000, ram_q[ram_idx_s]};
        end else begin
            case (off_s)
                OFF_CTRL:   rdata_s = {31'h0000_0000, run_q};
                OFF_PERIOD: rdata_s = {16'h0000, period_q};
                OFF_LAST:   rdata_s = {{(32-AW){1'b0}}, last_q};
                default:    rdata_s = 32'h0000_0000;
            endcase
        end
    end

    // Next playback index: wrap after LAST; past LAST it free-runs and wraps at AW bits
    always_comb begin
        if (index_q == last_q) begin
            index_d = {AW{1'b0}};
        end else begin
            index_d = index_q + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    // Wishbone handshake and control registers; writes commit at the end of the ack cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0000_0000;
            req_wr_q  <= 1'b0;
            req_off_q <= 11'h000;
            req_dat_q <= 16'h0000;
            run_q     <= 1'b0;
            period_q  <= 16'h0000;
            last_q    <= {AW{1'b0}};
        end else begin
            ack_q <= hit_s;
            dat_q <= (hit_s && !wbs_we_i) ? rdata_s : 32'h0000_0000;
            if (hit_s) begin
                req_wr_q  <= wbs_we_i & wbs_sel_i[0];
                req_off_q <= off_s;
                req_dat_q <= wbs_dat_i[15:0];
            end
            if (ack_q && req_wr_q) begin
                case (req_off_q)
                    OFF_CTRL:   run_q    <= req_dat_q[0];
                    OFF_PERIOD: period_q <= req_dat_q;
                    OFF_LAST:   last_q   <= req_dat_q[AW-1:0];
                    default:    ; // RAM words are handled by the RAM block; others are ignored
                endcase
            end
        end
    end

    // Sample RAM write port (contents are not reset)
    always_ff @(posedge wb_clk_i) begin
        if (ack_q && req_wr_q && is_ram_off(req_off_q)) begin
            ram_q[req_off_q[AW+1:2]] <= req_dat_q[7:0];
        end
    end

    // Playback FSM; a same-cycle RAM write to index_q is seen one sample later
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            index_q     <= {AW{1'b0}};
            cnt_q       <= 16'h0000;
            dac_q       <= 8'h00;
            dac_start_q <= 1'b0;
        end else begin
            dac_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run_q) begin
                        state_q <= ST_RUN;
                        index_q <= {AW{1'b0}};
                        cnt_q   <= 16'h0000;
                    end
                end
                ST_RUN: begin
                    if (!run_q) begin
                        state_q <= ST_IDLE;
                        index_q <= {AW{1'b0}};
                        cnt_q   <= 16'h0000;
                    end else if (cnt_q == period_q) begin
                        cnt_q       <= 16'h0000;
                        dac_q       <= ram_q[index_q];
                        dac_start_q <= 1'b1;
                        index_q     <= index_d;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    index_q <= {AW{1'b0}};
                    cnt_q   <= 16'h0000;
                end
            endcase
        end
    end

    assign wbs_ack_o          = ack_q;
    assign wbs_dat_o          = dat_q;
    // Deselecting the project blanks the pins but the FSM keeps running underneath.
    assign dac                = active ? dac_q : 8'h00;
    assign dbg_state_run      = active & (state_q == ST_RUN);
    assign dbg_ram_addr_zero  = active & (state_q == ST_RUN) & (index_q == {AW{1'b0}});
    assign dbg_dac_start      = active & dac_start_q;
    assign dbg_ram_wb_stb     = active & bus_req_s & win_s & ram_sel_s;
    assign dbg_caravel_wb_stb = bus_req_s;
    assign dbg_active         = active;

endmodule

// File: tb/tb_function_generator.sv
module tb_function_generator;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        active;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  dac;
    logic        dbg_ram_addr_zero;
    logic        dbg_state_run;
    logic        dbg_dac_start;
    logic        dbg_ram_wb_stb;
    logic        dbg_caravel_wb_stb;
    logic        dbg_active;

    function_generator dut (
        .wb_clk_i           (wb_clk_i),
        .wb_rst_i           (wb_rst_i),
        .active             (active),
        .wbs_stb_i          (wbs_stb_i),
        .wbs_cyc_i          (wbs_cyc_i),
        .wbs_we_i           (wbs_we_i),
        .wbs_sel_i          (wbs_sel_i),
        .wbs_adr_i          (wbs_adr_i),
        .wbs_dat_i          (wbs_dat_i),
        .wbs_ack_o          (wbs_ack_o),
        .wbs_dat_o          (wbs_dat_o),
        .dac                (dac),
        .dbg_ram_addr_zero  (dbg_ram_addr_zero),
        .dbg_state_run      (dbg_state_run),
        .dbg_dac_start      (dbg_dac_start),
        .dbg_ram_wb_stb     (dbg_ram_wb_stb),
        .dbg_caravel_wb_stb (dbg_caravel_wb_stb),
        .dbg_active         (dbg_active)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_PERIOD = 32'h3000_0004;
    localparam logic [31:0] A_LAST   = 32'h3000_0008;
    localparam logic [31:0] A_RAM    = 32'h3000_0400;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rexp;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] exp3 [5];
    logic [31:0] sb_q [$];
    int          total = 0;
    int          bad   = 0;
    int          gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_ram(input logic [31:0] a);
        return (a[31:11] == 21'h06_0000) && a[10] && (a[9:7] == 3'b000) && (a[1:0] == 2'b00);
    endfunction

    task automatic bus_idle();
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'b0000;
        wbs_adr_i = 32'h0000_0000;
        wbs_dat_i = 32'h0000_0000;
    endtask

    // Drive one access, require ack on the 2nd negedge after the strobe, then a clean release.
    task automatic wb_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] sel, input string tag);
        int   n;
        logic got;
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = addr;
        wbs_dat_i = data;
        @(negedge wb_clk_i);
        n = 1;
        got = wbs_ack_o;
        check1({tag, "_ram_stb"}, dbg_ram_wb_stb, is_ram(addr));
        while (!got && n < 8) begin
            @(negedge wb_clk_i);
            n++;
            got = wbs_ack_o;
        end
        check({tag, "_ack_lat"}, got ? n : 0, 32'd2);
        @(posedge wb_clk_i); #1;
        bus_idle();
        @(negedge wb_clk_i);
        check1({tag, "_no_dbl_ack"}, wbs_ack_o, 1'b0);
        if (!got && !we && sb_q.size() > 0) begin
            void'(sb_q.pop_back());
        end
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        wb_access(1'b1, addr, data, sel, "wr");
    endtask

    task automatic wb_read(input logic [31:0] addr, input logic [31:0] exp);
        sb_q.push_back(exp);
        wb_access(1'b0, addr, 32'h0000_0000, 4'b0001, "rd");
    endtask

    // Strobe without expecting any acknowledge.
    task automatic probe(input logic [31:0] addr, input int cycles, input logic exp_ram_stb);
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'b0001;
        wbs_adr_i = addr;
        for (int i = 0; i < cycles; i++) begin
            @(negedge wb_clk_i);
            check1("probe_no_ack", wbs_ack_o, 1'b0);
            check1("probe_caravel_stb", dbg_caravel_wb_stb, 1'b1);
            check1("probe_ram_stb", dbg_ram_wb_stb, exp_ram_stb);
        end
        @(posedge wb_clk_i); #1;
        bus_idle();
    endtask

    task automatic wait_run(input logic want);
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            if (dbg_state_run == want) break;
        end
        check1("run_state", dbg_state_run, want);
    endtask

    // Count negedges until the next DAC update; gap = 0 on timeout.
    task automatic wait_start(input int budget, output int g);
        g = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge wb_clk_i);
            if (dbg_dac_start) begin
                g = i;
                break;
            end
        end
    endtask

    // Scoreboard: every read acknowledge pops the oldest expected value.
    always @(negedge wb_clk_i) begin
        if (wbs_ack_o && !wbs_we_i) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_ack: got data %0h expected no ack", wbs_dat_o);
            end else begin
                check("rd_data", wbs_dat_o, sb_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h3000_0004, 32'h0000_0005, 4'b0001, 32'h0000_0005};
        vecs[1] = '{32'h3000_0008, 32'hFFFF_FFE3, 4'b0001, 32'h0000_0003};
        vecs[2] = '{32'h3000_0004, 32'h0012_3456, 4'b0001, 32'h0000_3456};
        vecs[3] = '{32'h3000_0004, 32'h0000_0009, 4'b1110, 32'h0000_3456};
        vecs[4] = '{32'h3000_0010, 32'h0000_0077, 4'b0001, 32'h0000_0000};
        vecs[5] = '{32'h3000_0400, 32'h0000_01AB, 4'b0001, 32'h0000_00AB};
        vecs[6] = '{32'h3000_047C, 32'h0000_005A, 4'b0001, 32'h0000_005A};
        vecs[7] = '{32'h3000_0480, 32'h0000_0033, 4'b0001, 32'h0000_0000};
        vecs[8] = '{32'h3000_0000, 32'hFFFF_FFFE, 4'b0001, 32'h0000_0000};
        exp3[0] = 32'd10; exp3[1] = 32'd20; exp3[2] = 32'd30; exp3[3] = 32'd40; exp3[4] = 32'd10;

        wb_rst_i = 1'b1;
        active   = 1'b1;
        bus_idle();
        #3;
        check1("rst_ack", wbs_ack_o, 1'b0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_dac", {24'h0, dac}, 32'h0);
        check1("rst_run", dbg_state_run, 1'b0);
        check1("rst_start", dbg_dac_start, 1'b0);
        check1("rst_azero", dbg_ram_addr_zero, 1'b0);
        check1("rst_active", dbg_active, 1'b1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Register/RAM map: write then read back
        for (int i = 0; i < 9; i++) begin
            wb_write(vecs[i].addr, vecs[i].wdata, vecs[i].sel);
            wb_read(vecs[i].addr, vecs[i].rexp);
        end
        probe(32'h3000_0800, 3, 1'b0);

        // Playback of four samples, PERIOD=3
        wb_write(A_RAM + 32'h0, 32'd10, 4'b0001);
        wb_write(A_RAM + 32'h4, 32'd20, 4'b0001);
        wb_write(A_RAM + 32'h8, 32'd30, 4'b0001);
        wb_write(A_RAM + 32'hC, 32'd40, 4'b0001);
        wb_write(A_LAST, 32'd3, 4'b0001);
        wb_write(A_PERIOD, 32'd3, 4'b0001);
        wb_write(A_CTRL, 32'd1, 4'b0001);
        wait_run(1'b1);
        check1("p3_azero_enter", dbg_ram_addr_zero, 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_start(20, gap);
            check("p3_gap", gap, 32'd4);
            check("p3_dac", {24'h0, dac}, exp3[k]);
            check1("p3_azero", dbg_ram_addr_zero, k == 3);
        end
        wb_write(A_CTRL, 32'd0, 4'b0001);
        wait_run(1'b0);

        // Stop mid-run freezes dac; restart begins at RAM[0]
        wb_write(A_PERIOD, 32'd7, 4'b0001);
        wb_write(A_CTRL, 32'd1, 4'b0001);
        wait_run(1'b1);
        wait_start(20, gap);
        check("p7_gap", gap, 32'd8);
        check("p7_dac", {24'h0, dac}, 32'd10);
        wb_write(A_CTRL, 32'd0, 4'b0001);
        wait_run(1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            check("stop_dac_frozen", {24'h0, dac}, 32'd10);
            check1("stop_no_start", dbg_dac_start, 1'b0);
            check1("stop_run", dbg_state_run, 1'b0);
        end
        wb_write(A_CTRL, 32'd1, 4'b0001);
        wait_run(1'b1);
        wait_start(20, gap);
        check("restart_gap", gap, 32'd8);
        check("restart_dac", {24'h0, dac}, 32'd10);
        wb_write(A_CTRL, 32'd0, 4'b0001);
        wait_run(1'b0);

        // PERIOD=0, LAST=0: same sample every clock
        wb_write(A_PERIOD, 32'd0, 4'b0001);
        wb_write(A_LAST, 32'd0, 4'b0001);
        wb_write(A_RAM, 32'h0000_00AA, 4'b0001);
        wb_write(A_CTRL, 32'd1, 4'b0001);
        wait_run(1'b1);
        wait_start(5, gap);
        check("p0_gap", gap, 32'd1);
        check("p0_dac", {24'h0, dac}, 32'h0000_00AA);
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            check1("p0_start_every_clk", dbg_dac_start, 1'b1);
            check("p0_dac_hold", {24'h0, dac}, 32'h0000_00AA);
        end
        // RAM write while running takes effect on the following sample
        wb_write(A_RAM, 32'h0000_0055, 4'b0001);
        @(negedge wb_clk_i);
        check("run_ram_write", {24'h0, dac}, 32'h0000_0055);

        // Asynchronous reset mid-run
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("mid_rst_dac", {24'h0, dac}, 32'h0);
        check1("mid_rst_run", dbg_state_run, 1'b0);
        check1("mid_rst_start", dbg_dac_start, 1'b0);
        check1("mid_rst_ack", wbs_ack_o, 1'b0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wb_read(A_CTRL, 32'h0);
        wb_read(A_PERIOD, 32'h0);
        check1("post_rst_idle", dbg_state_run, 1'b0);

        // active=0 blanks outputs and blocks the bus; FSM keeps running
        wb_write(A_CTRL, 32'd1, 4'b0001);
        wait_run(1'b1);
        @(negedge wb_clk_i);
        check("act_dac_before", {24'h0, dac}, 32'h0000_0055);
        active = 1'b0;
        #1;
        check("inact_dac", {24'h0, dac}, 32'h0);
        check1("inact_run", dbg_state_run, 1'b0);
        check1("inact_start", dbg_dac_start, 1'b0);
        check1("inact_azero", dbg_ram_addr_zero, 1'b0);
        check1("inact_active", dbg_active, 1'b0);
        probe(A_RAM, 3, 1'b0);
        #1;
        check("inact_dac_after", {24'h0, dac}, 32'h0);
        @(negedge wb_clk_i);
        active = 1'b1;
        #1;
        check1("react_run", dbg_state_run, 1'b1);
        check("react_dac", {24'h0, dac}, 32'h0000_0055);
        check1("react_start", dbg_dac_start, 1'b1);
        wb_write(A_CTRL, 32'd0, 4'b0001);
        wait_run(1'b0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
